keypad_scanner_n: RTL and testbench
===================================

KEYPAD_SCANNER_N -- requirements
Module: keypad_scanner_n

Interface
REQ-001 The block SHALL have parameter NROWS, default 4, number of driven keypad rows (>=2).
REQ-002 The block SHALL have parameter NCOLS, default 4, number of sensed keypad columns (>=2).
REQ-003 The block SHALL have parameter SCAN_DWELL, default 4, cycles each row is driven while scanning (>=3).
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a press or a release (>=1).
REQ-005 The block SHALL derive CODE_W = clog2(NROWS*NCOLS) internally; it is not a user parameter.
REQ-006 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port columns, input, NCOLS, raw keypad columns, active-low, asynchronous to clk.
REQ-009 The block SHALL have port rows, output, NROWS, one-hot active-high row drive.
REQ-010 The block SHALL have port key_code, output, CODE_W, index of the last accepted key.
REQ-011 The block SHALL have port key_valid, output, 1, single-cycle pulse on each accepted press.
REQ-012 The block SHALL have port key_held, output, 1, high while an accepted key is held.

Function
REQ-013 The block SHALL pass columns through a 2-flop synchronizer; all decisions use the synchronized value (csync).
REQ-014 Row index r SHALL drive rows[NROWS-1-r]; column index c SHALL correspond to columns[NCOLS-1-c].
REQ-015 key_code SHALL equal r*NCOLS + c for the accepted key and SHALL hold until the next accepted press.
REQ-016 The FSM SHALL have states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-017 SCAN: row r driven for SCAN_DWELL cycles; on the last dwell cycle csync is sampled.
REQ-018 SCAN sample with exactly one column low: latch c, go to DEBOUNCE, keep row r driven, clear debounce counter.
REQ-019 SCAN sample with zero or more than one column low: advance to row (r+1) mod NROWS, dwell counter restarts at 0.
REQ-020 DEBOUNCE: each cycle csync equals the latched one-low pattern increments the counter; after DEBOUNCE_CYCLES matching cycles go to HELD.
REQ-021 DEBOUNCE mismatch on any cycle: return to SCAN at row (r+1) mod NROWS, no output change.
REQ-022 On entry to HELD: update key_code, assert key_valid for exactly the first HELD cycle, set key_held=1.
REQ-023 HELD: rows stay on row r; additional columns going low SHALL be ignored; latched column going high moves to RELEASE with counter cleared.
REQ-024 RELEASE: latched column high for DEBOUNCE_CYCLES consecutive cycles returns to SCAN at row (r+1) mod NROWS with key_held=0.
REQ-025 RELEASE: latched column low again returns to HELD, counter cleared, no new key_valid.
REQ-026 key_held SHALL be 1 in HELD and RELEASE, 0 in SCAN and DEBOUNCE.
REQ-027 Press latency: key_valid SHALL rise DEBOUNCE_CYCLES+1 cycles after the SCAN sample edge.

Reset
REQ-028 While reset=0, asynchronously: state=SCAN, row index 0 (rows=1 at MSB, i.e. 4'b1000 by default), dwell and debounce counters=0, key_code=0, key_valid=0, key_held=0, synchronizer flops=all ones.
REQ-029 Reset asserted in any state, including HELD mid-press, SHALL take effect without waiting for clk; scanning restarts at row 0 on the first edge after release.

Verification (defaults NROWS=4, NCOLS=4, SCAN_DWELL=4, DEBOUNCE_CYCLES=4)
REQ-030 Idle: columns=1111 -> rows cycles 1000,0100,0010,0001,1000, each held 4 cycles; key_valid never high.
REQ-031 Keypad model: row1/col2 pressed (columns=1101 when rows=0100) -> one key_valid pulse, key_code=6, key_held=1, rows frozen at 0100 until release.
REQ-032 Bounce: columns low for 2 cycles during DEBOUNCE -> no key_valid; scan resumes at the next row.
REQ-033 Multi-key: columns=0011 while rows=1000 -> no key_valid; rows advances to 0100.
REQ-034 Release glitch: in HELD, latched column high 2 cycles then low -> back to HELD, key_held stays 1, no second key_valid; full 4-cycle release -> key_held=0, scan resumes.
REQ-035 Reset mid-HELD: reset=0 -> rows=1000, key_code=0, key_held=0, key_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/keypad_scanner_n.sv
// Row-scanning keypad controller: drives one row at a time, samples the synchronized
// active-low columns, debounces presses and releases, and reports the accepted key code.
module keypad_scanner_n #(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CODE_W         = $clog2(NROWS * NCOLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCOLS-1:0]  columns,
  output logic [NROWS-1:0]  rows,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int ROW_W   = $clog2(NROWS);
  localparam int COL_W   = $clog2(NCOLS);
  localparam int DWELL_W = $clog2(SCAN_DWELL);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NCOLS-1:0]    sync1_q, sync1_d;
  logic [NCOLS-1:0]    sync2_q, sync2_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;

  logic [NCOLS-1:0]    csync;
  logic [NCOLS-1:0]    lat_pat;
  logic [COL_W-1:0]    hit_col;
  logic                seen_one, seen_many, one_low;
  logic                col_high;
  logic [ROW_W-1:0]    next_row;

  assign csync = sync2_q;

  // Classify the synchronized columns and build the pattern expected for the latched column.
  always_comb begin
    seen_one  = 1'b0;
    seen_many = 1'b0;
    hit_col   = '0;
    lat_pat   = '1;
    for (int c = 0; c < NCOLS; c++) begin
      if (!csync[NCOLS-1-c]) begin
        if (seen_one) seen_many = 1'b1;
        seen_one = 1'b1;
        hit_col  = COL_W'(c);
      end
      if (col_q == COL_W'(c)) lat_pat[NCOLS-1-c] = 1'b0;
    end
    one_low  = seen_one & ~seen_many;
    col_high = |(~lat_pat & csync);
    next_row = (row_q == ROW_W'(NROWS - 1)) ? '0 : row_q + ROW_W'(1);
  end

  always_comb begin
    rows = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (row_q == ROW_W'(r)) rows[NROWS-1-r] = 1'b1;
    end
  end

  always_comb begin
    sync1_d     = columns;
    sync2_d     = sync1_q;
    state_d     = state_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    col_d       = col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_W'(SCAN_DWELL - 1)) begin
          dwell_d = '0;
          if (one_low) begin
            state_d = ST_DEBOUNCE;
            col_d   = hit_col;
            deb_d   = '0;
          end else begin
            row_d = next_row;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      // Counter reaches DEBOUNCE_CYCLES after that many matches; the commit happens one
      // cycle later, so key_valid lands DEBOUNCE_CYCLES+1 cycles after the scan sample.
      ST_DEBOUNCE: begin
        if (csync != lat_pat) begin
          state_d = ST_SCAN;
          row_d   = next_row;
          dwell_d = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES)) begin
          state_d     = ST_HELD;
          deb_d       = '0;
          key_valid_d = 1'b1;
          key_code_d  = CODE_W'(row_q) * CODE_W'(NCOLS) + CODE_W'(col_q);
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      ST_HELD: begin
        if (col_high) begin
          state_d = ST_RELEASE;
          deb_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (!col_high) begin
          state_d = ST_HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d = ST_SCAN;
          row_d   = next_row;
          dwell_d = '0;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      sync1_q     <= '1;
      sync2_q     <= '1;
      row_q       <= '0;
      dwell_q     <= '0;
      deb_q       <= '0;
      col_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner_n.sv
// Directed bench for keypad_scanner_n: a keypad model answers the driven row with the
// column pattern of the key(s) held on that row; each task checks one scenario.
module tb_keypad_scanner_n;

  logic       clk;
  logic       reset;
  logic [3:0] columns;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // kp[r] is the raw column pattern seen while row r is driven.
  logic [3:0] kp [4] = '{default: 4'b1111};

  int n_cmp = 0;
  int n_err = 0;

  keypad_scanner_n #(
    .NROWS(4), .NCOLS(4), .SCAN_DWELL(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .columns(columns),
    .rows(rows), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    columns = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (rows[3-r]) columns = kp[r];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge on which row r starts being driven (dwell 0).
  task automatic wait_row_start(input int r);
    logic [3:0] target, prev;
    bit found;
    target = 4'b1000 >> r;
    prev   = rows;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (rows == target && prev != target) found = 1'b1;
      prev = rows;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_row%0d: rows=%b, row start %b never seen", r, rows, target);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    n_cmp++; if (rows !== 4'b1000) begin n_err++; $display("FAIL reset_rows: got %b want %b", rows, 4'b1000); end
    n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", key_code); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b want 0", key_held); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Idle scan: each row is driven for 4 cycles, wrapping back to row 0.
  task automatic test_idle;
    logic [3:0] exp_rows;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      exp_rows = 4'b1000 >> ((k / 4) % 4);
      n_cmp++; if (rows !== exp_rows) begin n_err++; $display("FAIL idle_rows k=%0d: got %b want %b", k, rows, exp_rows); end
      n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid k=%0d: got %b want 0", k, key_valid); end
    end
  endtask

  // Row 1 / column 2 press: sample at dwell+4, key_valid 5 cycles later.
  task automatic test_press;
    kp[1] = 4'b1101;
    wait_row_start(1);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      n_cmp++; if (key_valid !== (k == 9)) begin n_err++; $display("FAIL press_valid k=%0d: got %b want %b", k, key_valid, (k == 9)); end
      n_cmp++; if (rows !== 4'b0100) begin n_err++; $display("FAIL press_rows k=%0d: got %b want 0100", k, rows); end
      if (k == 8) begin
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL press_held_early: got %b want 0", key_held); end
      end
      if (k == 9) begin
        n_cmp++; if (key_code !== 4'd6) begin n_err++; $display("FAIL press_code: got %0d want 6", key_code); end
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL press_held: got %b want 1", key_held); end
      end
    end
  endtask

  // While held: an extra column is ignored, and a 2-cycle release glitch keeps the key held.
  task automatic test_held_glitch;
    kp[1] = 4'b1100;
    step(4);
    kp[1] = 4'b1101;
    step(2);
    kp[1] = 4'b1111;
    step(2);
    kp[1] = 4'b1101;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL glitch_held k=%0d: got %b want 1", k, key_held); end
      n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid k=%0d: got %b want 0", k, key_valid); end
    end
    n_cmp++; if (rows !== 4'b0100) begin n_err++; $display("FAIL glitch_rows: got %b want 0100", rows); end
  endtask

  // Full release: key_held drops 7 cycles after the raw column rises, scan resumes at row 2.
  task automatic test_release;
    kp[1] = 4'b1111;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      n_cmp++; if (key_held !== (k < 7)) begin n_err++; $display("FAIL release_held k=%0d: got %b want %b", k, key_held, (k < 7)); end
    end
    n_cmp++; if (rows !== 4'b0010) begin n_err++; $display("FAIL release_rows: got %b want 0010", rows); end
    n_cmp++; if (key_code !== 4'd6) begin n_err++; $display("FAIL release_code: got %0d want 6", key_code); end
  endtask

  // Column low for only 2 debounce cycles: no key, scan moves from row 3 to row 0.
  task automatic test_bounce;
    kp[3] = 4'b0111;
    wait_row_start(3);
    step(4);
    kp[3] = 4'b1111;
    for (int k = 5; k <= 12; k++) begin
      step(1);
      n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL bounce_valid k=%0d: got %b want 0", k, key_valid); end
      if (k == 6) begin
        n_cmp++; if (rows !== 4'b0001) begin n_err++; $display("FAIL bounce_rows_frozen: got %b want 0001", rows); end
      end
      if (k == 7) begin
        n_cmp++; if (rows !== 4'b1000) begin n_err++; $display("FAIL bounce_rows_next: got %b want 1000", rows); end
      end
    end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL bounce_held: got %b want 0", key_held); end
    n_cmp++; if (key_code !== 4'd6) begin n_err++; $display("FAIL bounce_code: got %0d want 6", key_code); end
  endtask

  // Two columns low on row 0: treated as no key, scanning keeps advancing.
  task automatic test_multi_key;
    kp[0] = 4'b0011;
    wait_row_start(0);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL multi_valid k=%0d: got %b want 0", k, key_valid); end
      if (k == 3) begin
        n_cmp++; if (rows !== 4'b1000) begin n_err++; $display("FAIL multi_rows3: got %b want 1000", rows); end
      end
      if (k == 4) begin
        n_cmp++; if (rows !== 4'b0100) begin n_err++; $display("FAIL multi_rows4: got %b want 0100", rows); end
      end
      if (k == 8) begin
        n_cmp++; if (rows !== 4'b0010) begin n_err++; $display("FAIL multi_rows8: got %b want 0010", rows); end
      end
    end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL multi_held: got %b want 0", key_held); end
    kp[0] = 4'b1111;
  endtask

  // Press row 3 / column 3 (code 15), then assert reset during the key_valid cycle.
  task automatic test_reset_mid_held;
    kp[3] = 4'b1110;
    wait_row_start(3);
    step(9);
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid: got %b want 1", key_valid); end
    n_cmp++; if (key_code !== 4'd15) begin n_err++; $display("FAIL mid_code: got %0d want 15", key_code); end
    n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL mid_held: got %b want 1", key_held); end
    #3;
    reset = 1'b0;
    #1;
    n_cmp++; if (rows !== 4'b1000) begin n_err++; $display("FAIL async_rows: got %b want 1000", rows); end
    n_cmp++; if (key_code !== 4'd0) begin n_err++; $display("FAIL async_code: got %0d want 0", key_code); end
    n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL async_held: got %b want 0", key_held); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", key_valid); end
    kp[3] = 4'b1111;
    @(negedge clk);
    reset = 1'b1;
    step(3);
    n_cmp++; if (rows !== 4'b1000) begin n_err++; $display("FAIL restart_row0: got %b want 1000", rows); end
    step(1);
    n_cmp++; if (rows !== 4'b0100) begin n_err++; $display("FAIL restart_row1: got %b want 0100", rows); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press();
    test_held_glitch();
    test_release();
    test_bounce();
    test_multi_key();
    test_reset_mid_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
